// File: rtl/match_trigger_pkg.sv
// Shared types and default sizing for the match trigger unit.
package match_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_e;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TS_W        = 16;
    localparam int DEF_THRESH      = 2;
    localparam int DEF_HOLDOFF_CYC = 4;
    localparam int DEF_AUTO_REARM  = 0;

    localparam int ARM_CNT_W = 8;

endpackage

// File: rtl/match_trigger_unit_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         overflow
);

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    // NOTE: every _d is given its _q value first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/match_trigger_unit.sv
// Counts and timestamps detector matches; raises a latched irq after THRESH matches once armed.
module match_trigger_unit
    import match_trigger_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TS_W        = DEF_TS_W,
    parameter int THRESH      = DEF_THRESH,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int AUTO_REARM  = DEF_AUTO_REARM
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sequence_found,
    input  logic             arm,
    input  logic             irq_ack,
    input  logic             clear_count,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             irq,
    output logic [TS_W-1:0]  trig_time,
    output logic [1:0]       state
);

    localparam int HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HO_W-1:0]      HO_LAST     = HO_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
    localparam logic [ARM_CNT_W-1:0] THRESH_LAST = ARM_CNT_W'(THRESH - 1);
    localparam state_e               EXIT_STATE  = (AUTO_REARM != 0) ? ST_ARMED : ST_IDLE;

    state_e                state_q, state_d;
    logic [ARM_CNT_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [HO_W-1:0]       holdoff_cnt_q, holdoff_cnt_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [TS_W-1:0]       trig_time_q, trig_time_d;
    logic                  irq_q, irq_d;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (sequence_found),
        .clr      (clear_count),
        .count    (match_count),
        .overflow (overflow)
    );

    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        holdoff_cnt_d = holdoff_cnt_q;
        trig_time_d   = trig_time_q;
        irq_d         = irq_q;
        ts_d          = ts_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    arm_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                // The timestamp captured is that of the cycle in which the firing match was sampled.
                if (sequence_found) begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    if (arm_cnt_q == THRESH_LAST) begin
                        state_d     = ST_TRIGGERED;
                        irq_d       = 1'b1;
                        trig_time_d = ts_q;
                    end
                end
            end
            ST_TRIGGERED: begin
                if (irq_ack) begin
                    irq_d = 1'b0;
                    if (HOLDOFF_CYC == 0) begin
                        state_d   = EXIT_STATE;
                        arm_cnt_d = '0;
                    end else begin
                        state_d       = ST_HOLDOFF;
                        holdoff_cnt_d = '0;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_cnt_q == HO_LAST) begin
                    state_d   = EXIT_STATE;
                    arm_cnt_d = '0;
                end else begin
                    holdoff_cnt_d = holdoff_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            arm_cnt_q     <= '0;
            holdoff_cnt_q <= '0;
            ts_q          <= '0;
            trig_time_q   <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            ts_q          <= ts_d;
            trig_time_q   <= trig_time_d;
            irq_q         <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign trig_time = trig_time_q;
    assign state     = state_q;

endmodule

// File: tb/tb_match_trigger_unit.sv
// Directed bench: default instance plus an AUTO_REARM/zero-holdoff instance, both checked against a cycle model.
module tb_match_trigger_unit;

    logic clk = 1'b0;
    logic reset_n, arm, sf, ack, clr;

    logic [7:0]  cnt1, cnt2;
    logic        ovf1, ovf2, irq1, irq2;
    logic [15:0] tt1, tt2;
    logic [1:0]  st1, st2;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    match_trigger_unit dut1 (
        .clk(clk), .reset_n(reset_n), .sequence_found(sf), .arm(arm), .irq_ack(ack),
        .clear_count(clr), .match_count(cnt1), .overflow(ovf1), .irq(irq1),
        .trig_time(tt1), .state(st1)
    );

    match_trigger_unit #(.HOLDOFF_CYC(0), .AUTO_REARM(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .sequence_found(sf), .arm(arm), .irq_ack(ack),
        .clear_count(clr), .match_count(cnt2), .overflow(ovf2), .irq(irq2),
        .trig_time(tt2), .state(st2)
    );

    // mode: 0 idle, 1 armed, 2 triggered, 3 holdoff; left counts holdoff cycles still to spend.
    typedef struct {
        int ts;
        int count;
        int ovf;
        int mode;
        int hits;
        int left;
        int trig;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_next(input mdl_t m, input bit a, input bit s, input bit k,
                                      input bit c, input int thresh, input int hold,
                                      input bit rearm);
        mdl_t n = m;
        n.ts = (m.ts + 1) % 65536;
        if (c) begin
            n.count = 0;
            n.ovf   = 0;
        end else if (s) begin
            if (m.count == 255) n.ovf = 1;
            else                n.count = m.count + 1;
        end
        case (m.mode)
            0: if (a) begin n.mode = 1; n.hits = 0; end
            1: if (s) begin
                n.hits = m.hits + 1;
                if (n.hits == thresh) begin n.mode = 2; n.trig = m.ts; end
            end
            2: if (k) begin
                if (hold == 0) begin n.mode = rearm ? 1 : 0; n.hits = 0; end
                else           begin n.mode = 3; n.left = hold; end
            end
            default: begin
                n.left = m.left - 1;
                if (n.left == 0) begin n.mode = rearm ? 1 : 0; n.hits = 0; end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1 <= '{default: 0};
            m2 <= '{default: 0};
        end else begin
            m1 <= mdl_next(m1, arm, sf, ack, clr, 2, 4, 1'b0);
            m2 <= mdl_next(m2, arm, sf, ack, clr, 2, 0, 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic [7:0] cnt, input logic ovf,
                       input logic irq, input logic [15:0] tt, input logic [1:0] st);
        check({tag, ".match_count"}, 32'(cnt), 32'(m.count));
        check({tag, ".overflow"},    32'(ovf), 32'(m.ovf));
        check({tag, ".irq"},         32'(irq), (m.mode == 2) ? 32'd1 : 32'd0);
        check({tag, ".trig_time"},   32'(tt),  32'(m.trig));
        check({tag, ".state"},       32'(st),  32'(m.mode));
    endtask

    always @(negedge clk) begin
        cmp("dut1", m1, cnt1, ovf1, irq1, tt1, st1);
        cmp("dut2", m2, cnt2, ovf2, irq2, tt2, st2);
    end

    // Hold the given inputs across exactly one rising edge.
    task automatic step(input bit a, input bit s, input bit k, input bit c);
        arm = a; sf = s; ack = k; clr = c;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        check("rst.match_count", 32'(cnt1), 32'd0);
        check("rst.overflow",    32'(ovf1), 32'd0);
        check("rst.irq",         32'(irq1), 32'd0);
        check("rst.trig_time",   32'(tt1),  32'd0);
        check("rst.state",       32'(st1),  32'd0);
        check("rst.dut2_state",  32'(st2),  32'd0);
        arm = 0; sf = 0; ack = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; arm = 0; sf = 0; ack = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Scenario 1: quiet after reset, then an asynchronous mid-cycle reset.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("s1.match_count", 32'(cnt1), 32'd0);
        check("s1.irq",         32'(irq1), 32'd0);
        check("s1.state",       32'(st1),  32'd0);
        check("s1.trig_time",   32'(tt1),  32'd0);
        reset_pulse();

        // Scenario 2: arm at ts=3, matches at ts=5 and ts=7.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("s2.armed", 32'(st1), 32'd1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("s2.one_hit_state", 32'(st1), 32'd1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("s2.state",       32'(st1),  32'd2);
        check("s2.irq",         32'(irq1), 32'd1);
        check("s2.trig_time",   32'(tt1),  32'd7);
        check("s2.match_count", 32'(cnt1), 32'd2);

        // Scenario 3: irq held until acked, then exactly 4 holdoff cycles ignoring arm.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check("s3.irq_held", 32'(irq1), 32'd1);
        end
        step(0, 0, 1, 0);
        check("s3.irq_after_ack", 32'(irq1), 32'd0);
        check("s3.holdoff_1",     32'(st1),  32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            check("s3.holdoff_n", 32'(st1), 32'd3);
        end
        step(1, 0, 0, 0);
        check("s3.back_idle", 32'(st1), 32'd0);

        // Scenario 4: a match coinciding with arm does not count toward the threshold.
        step(0, 0, 0, 1);
        check("s4.cleared", 32'(cnt1), 32'd0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("s4.match_count", 32'(cnt1), 32'd2);
        check("s4.still_armed", 32'(st1),  32'd1);
        step(0, 1, 0, 0);
        check("s4.fired",     32'(st1), 32'd2);
        check("s4.trig_time", 32'(tt1), 32'd21);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("s4.idle", 32'(st1), 32'd0);

        // Scenario 5: saturation, sticky overflow, clear beating increment.
        step(0, 0, 0, 1);
        for (int i = 1; i <= 260; i++) begin
            step(0, 1, 0, 0);
            if (i == 255) begin
                check("s5.at_max",     32'(cnt1), 32'd255);
                check("s5.no_ovf_yet", 32'(ovf1), 32'd0);
            end
        end
        check("s5.saturated", 32'(cnt1), 32'd255);
        check("s5.overflow",  32'(ovf1), 32'd1);
        step(0, 1, 0, 1);
        check("s5.clr_count", 32'(cnt1), 32'd0);
        check("s5.clr_ovf",   32'(ovf1), 32'd0);
        step(0, 1, 0, 0);
        check("s5.post_clr", 32'(cnt1), 32'd1);

        // Reset while an irq is pending.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("pend.irq", 32'(irq1), 32'd1);
        reset_pulse();

        // Scenario 6: auto re-arm with no holdoff on dut2.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("s6.fire1_state", 32'(st2), 32'd2);
        check("s6.fire1_time",  32'(tt2), 32'd2);
        step(0, 0, 1, 0);
        check("s6.rearmed",      32'(st2),  32'd1);
        check("s6.irq_cleared",  32'(irq2), 32'd0);
        check("s6.dut1_holdoff", 32'(st1),  32'd3);
        step(0, 1, 0, 0);
        check("s6.one_hit", 32'(st2), 32'd1);
        step(0, 1, 0, 0);
        check("s6.fire2_state", 32'(st2),  32'd2);
        check("s6.fire2_irq",   32'(irq2), 32'd1);
        check("s6.fire2_time",  32'(tt2),  32'd5);
        check("s6.match_count", 32'(cnt2), 32'd4);
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
